// File: rtl/spi_transaction_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// spi_transaction_sequencer_pkg : shared types and defaults for the SPI sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_transaction_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } seq_state_e;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    localparam int DEF_CMD_DEPTH      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_INTER_GAP      = 2;

    // Command word layout: {op, slave[1:0], wdata[15:0]}
    localparam int CMD_W = 19;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_fifo.sv
// ----------------------------------------------------------------------------
// spi_cmd_fifo : synchronous command FIFO with registered full/empty, no bypass
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_cmd_fifo
    import spi_transaction_sequencer_pkg::*;
#(
    parameter int DEPTH = DEF_CMD_DEPTH,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW-1:0]    wptr_inc, rptr_inc;
    logic             full_q, empty_q;
    logic             full_d, empty_d;
    logic             push_ok, pop_ok;

    // A push is judged only against the registered full flag, so a
    // simultaneous pop never frees room for it.
    assign push_ok  = push_i & ~full_q;
    assign pop_ok   = pop_i & ~empty_q;
    assign wptr_inc = wptr_q + AW'(1);
    assign rptr_inc = rptr_q + AW'(1);

    always_comb begin
        full_d  = full_q;
        empty_d = empty_q;
        if (push_ok && !pop_ok) begin
            empty_d = 1'b0;
            full_d  = (wptr_inc == rptr_q);
        end else if (pop_ok && !push_ok) begin
            full_d  = 1'b0;
            empty_d = (rptr_inc == wptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) wptr_q <= wptr_inc;
            if (pop_ok)  rptr_q <= rptr_inc;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

`default_nettype wire

// File: rtl/spi_transaction_sequencer.sv
// ----------------------------------------------------------------------------
// spi_transaction_sequencer : queues SPI commands and runs them one at a time
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_transaction_sequencer
    import spi_transaction_sequencer_pkg::*;
#(
    parameter int CMD_DEPTH      = DEF_CMD_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int INTER_GAP      = DEF_INTER_GAP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_slave,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_op,
    output logic [1:0]  rsp_slave,
    output logic        rsp_timeout,
    output logic        spi_enable,
    output logic        spi_start_transaction,
    output logic [1:0]  spi_slave,
    output logic        spi_operation,
    output logic [15:0] spi_outgoing_data,
    input  logic        spi_end_of_transaction,
    input  logic [7:0]  spi_incoming_data,
    output logic [7:0]  timeout_count
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int GW = cnt_width(INTER_GAP);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST = GW'((INTER_GAP > 0) ? INTER_GAP - 1 : 0);

    seq_state_e        state_q;
    logic              enable_q, start_q;
    logic              op_q;
    logic [1:0]        slave_q;
    logic [15:0]       wdata_q;
    logic              rsp_valid_q, rsp_op_q, rsp_timeout_q;
    logic [7:0]        rsp_rdata_q;
    logic [1:0]        rsp_slave_q;
    logic [7:0]        tmo_count_q;
    logic [TW-1:0]     wait_cnt_q;
    logic [GW-1:0]     gap_cnt_q;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              head_op;
    logic [1:0]        head_slave;
    logic [15:0]       head_wdata;

    assign fifo_pop = (state_q == IDLE) && !fifo_empty;
    assign {head_op, head_slave, head_wdata} = fifo_rdata;

    spi_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_op, cmd_slave, cmd_wdata}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            enable_q      <= 1'b0;
            start_q       <= 1'b0;
            op_q          <= OP_WRITE;
            slave_q       <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_op_q      <= 1'b0;
            rsp_slave_q   <= '0;
            rsp_timeout_q <= 1'b0;
            tmo_count_q   <= '0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            enable_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_q    <= head_op;
                        slave_q <= head_slave;
                        wdata_q <= head_wdata;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q    <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= BUSY;
                end
                BUSY: begin
                    // End of transaction beats the timeout on the terminal cycle.
                    if (spi_end_of_transaction) begin
                        rsp_rdata_q   <= (op_q == OP_READ) ? spi_incoming_data : 8'h00;
                        rsp_timeout_q <= 1'b0;
                        rsp_op_q      <= op_q;
                        rsp_slave_q   <= slave_q;
                        rsp_valid_q   <= 1'b1;
                        start_q       <= 1'b0;
                        state_q       <= RESP;
                    end else if (wait_cnt_q == TMO_LAST) begin
                        rsp_rdata_q   <= 8'h00;
                        rsp_timeout_q <= 1'b1;
                        rsp_op_q      <= op_q;
                        rsp_slave_q   <= slave_q;
                        rsp_valid_q   <= 1'b1;
                        start_q       <= 1'b0;
                        if (tmo_count_q != 8'hFF) tmo_count_q <= tmo_count_q + 8'd1;
                        state_q       <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        gap_cnt_q   <= '0;
                        state_q     <= (INTER_GAP == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_q <= IDLE;
                    else                       gap_cnt_q <= gap_cnt_q + GW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready             = !fifo_full;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_rdata             = rsp_rdata_q;
    assign rsp_op                = rsp_op_q;
    assign rsp_slave             = rsp_slave_q;
    assign rsp_timeout           = rsp_timeout_q;
    assign spi_enable            = enable_q;
    assign spi_start_transaction = start_q;
    assign spi_slave             = slave_q;
    assign spi_operation         = op_q;
    assign spi_outgoing_data     = wdata_q;
    assign timeout_count         = tmo_count_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_transaction_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_transaction_sequencer : randomized self-checking bench for the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_transaction_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int GAPC  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic [1:0]  cmd_slave = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_op, rsp_timeout;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_slave;
    logic        spi_enable, spi_start_transaction, spi_operation;
    logic [1:0]  spi_slave;
    logic [15:0] spi_outgoing_data;
    logic        spi_end_of_transaction = 1'b0;
    logic [7:0]  spi_incoming_data = '0;
    logic [7:0]  timeout_count;

    always #5 clk = ~clk;

    spi_transaction_sequencer #(
        .CMD_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .INTER_GAP      (GAPC)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_op                 (cmd_op),
        .cmd_slave              (cmd_slave),
        .cmd_wdata              (cmd_wdata),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_rdata              (rsp_rdata),
        .rsp_op                 (rsp_op),
        .rsp_slave              (rsp_slave),
        .rsp_timeout            (rsp_timeout),
        .spi_enable             (spi_enable),
        .spi_start_transaction  (spi_start_transaction),
        .spi_slave              (spi_slave),
        .spi_operation          (spi_operation),
        .spi_outgoing_data      (spi_outgoing_data),
        .spi_end_of_transaction (spi_end_of_transaction),
        .spi_incoming_data      (spi_incoming_data),
        .timeout_count          (timeout_count)
    );

    typedef struct packed {
        logic        op;
        logic [1:0]  slave;
        logic [15:0] wdata;
    } cmd_t;

    // Reference model: commands in acceptance order plus expected timeout tally
    cmd_t q[$];
    int   exp_tmo_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic op, input logic [1:0] sl, input logic [15:0] wd, output bit acc);
        cmd_t c;
        cmd_valid = 1'b1; cmd_op = op; cmd_slave = sl; cmd_wdata = wd;
        acc = cmd_ready;
        tick;
        cmd_valid = 1'b0;
        if (acc) begin
            c.op = op; c.slave = sl; c.wdata = wd;
            q.push_back(c);
        end
    endtask

    task automatic service(input int eot_delay, input bit do_eot, input logic [7:0] din,
                           input int hold, output int low);
        cmd_t c;
        logic [7:0] exp_rd;
        logic       exp_to;
        int         n;
        bit         ok;
        low = 0;
        if (q.size() == 0) begin
            n_total++; $display("FAIL service_queue: model queue empty, expected a pending command");
            return;
        end
        c = q.pop_front();
        n = 0;
        while (spi_start_transaction !== 1'b1 && n < 200) begin tick; low++; n++; end
        n_total++;
        if (spi_start_transaction !== 1'b1) $display("FAIL start_wait: start=%b required 1 within 200 cycles", spi_start_transaction);
        else n_pass++;
        n_total++;
        if ({spi_operation, spi_slave, spi_outgoing_data} !== {c.op, c.slave, c.wdata})
            $display("FAIL spi_fields: got op=%b sl=%b wd=%h required op=%b sl=%b wd=%h",
                     spi_operation, spi_slave, spi_outgoing_data, c.op, c.slave, c.wdata);
        else n_pass++;
        if (do_eot) begin
            ok = 1'b1;
            repeat (eot_delay) begin
                tick;
                if (spi_start_transaction !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
            end
            n_total++;
            if (!ok) $display("FAIL busy_hold: start/rsp_valid changed while busy, required start=1 rsp_valid=0");
            else n_pass++;
            spi_end_of_transaction = 1'b1; spi_incoming_data = din;
            tick;
            spi_end_of_transaction = 1'b0; spi_incoming_data = 8'($urandom);
        end else begin
            repeat (TMO - 1) tick;
            n_total++;
            if (rsp_valid !== 1'b0) $display("FAIL early_timeout: rsp_valid=%b after %0d busy cycles, required 0", rsp_valid, TMO - 1);
            else n_pass++;
            tick;
        end
        exp_rd = (do_eot && c.op) ? din : 8'h00;
        exp_to = !do_eot;
        if (!do_eot && exp_tmo_cnt < 255) exp_tmo_cnt++;
        n_total++;
        if (rsp_valid !== 1'b1) $display("FAIL rsp_valid: got %b required 1", rsp_valid);
        else n_pass++;
        n_total++;
        if ({rsp_rdata, rsp_op, rsp_slave, rsp_timeout} !== {exp_rd, c.op, c.slave, exp_to})
            $display("FAIL rsp_fields: got rd=%h op=%b sl=%b to=%b required rd=%h op=%b sl=%b to=%b",
                     rsp_rdata, rsp_op, rsp_slave, rsp_timeout, exp_rd, c.op, c.slave, exp_to);
        else n_pass++;
        n_total++;
        if (timeout_count !== 8'(exp_tmo_cnt)) $display("FAIL timeout_count: got %0d required %0d", timeout_count, exp_tmo_cnt);
        else n_pass++;
        n_total++;
        if (spi_start_transaction !== 1'b0) $display("FAIL start_in_resp: got %b required 0", spi_start_transaction);
        else n_pass++;
        if (hold > 0) begin
            ok = 1'b1;
            repeat (hold) begin
                tick;
                if (rsp_valid !== 1'b1 || spi_start_transaction !== 1'b0 ||
                    {rsp_rdata, rsp_op, rsp_slave, rsp_timeout} !== {exp_rd, c.op, c.slave, exp_to}) ok = 1'b0;
            end
            n_total++;
            if (!ok) $display("FAIL rsp_stable: response changed or start rose before handshake (hold=%0d)", hold);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_total++;
        if (rsp_valid !== 1'b0) $display("FAIL rsp_release: rsp_valid=%b after handshake, required 0", rsp_valid);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        n_total++;
        if ({spi_enable, spi_start_transaction, rsp_valid} !== 3'b000)
            $display("FAIL reset_ctrl: en/start/rsp_valid=%b required 000", {spi_enable, spi_start_transaction, rsp_valid});
        else n_pass++;
        n_total++;
        if ({spi_slave, spi_operation, spi_outgoing_data, rsp_rdata, rsp_op, rsp_slave, rsp_timeout, timeout_count} !== '0)
            $display("FAIL reset_data: some data output nonzero, wd=%h rd=%h tc=%0d", spi_outgoing_data, rsp_rdata, timeout_count);
        else n_pass++;
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        else n_pass++;
        rst_n = 1'b1;
        tick;
        n_total++;
        if (spi_enable !== 1'b1) $display("FAIL enable_after_reset: got %b required 1", spi_enable);
        else n_pass++;
    endtask

    task automatic test_write_latency;
        bit acc; int low;
        push(1'b0, 2'b01, 16'hCC82, acc);
        n_total++;
        if (acc !== 1'b1) $display("FAIL write_accept: cmd_ready=%b required 1", acc);
        else n_pass++;
        n_total++;
        if (spi_start_transaction !== 1'b0) $display("FAIL latency_e0: start=%b required 0", spi_start_transaction);
        else n_pass++;
        tick;
        n_total++;
        if (spi_start_transaction !== 1'b0) $display("FAIL latency_e1: start=%b required 0", spi_start_transaction);
        else n_pass++;
        tick;
        n_total++;
        if (spi_start_transaction !== 1'b1) $display("FAIL latency_e2: start=%b required 1", spi_start_transaction);
        else n_pass++;
        service(40, 1'b1, 8'($urandom), 0, low);
    endtask

    task automatic test_read;
        bit acc; int low;
        push(1'b1, 2'b10, 16'($urandom), acc);
        service(int'($urandom_range(0, 20)), 1'b1, 8'h95, 0, low);
    endtask

    task automatic test_random;
        bit acc; int low;
        for (int i = 0; i < 8; i++) begin
            push(1'($urandom), 2'($urandom), 16'($urandom), acc);
            service(int'($urandom_range(0, TMO - 2)), 1'b1, 8'($urandom),
                    int'($urandom_range(0, 3)), low);
        end
    endtask

    task automatic test_timeout;
        bit acc; int low;
        push(1'($urandom), 2'($urandom), 16'($urandom), acc);
        service(0, 1'b0, 8'h00, 0, low);
        push(1'b1, 2'($urandom), 16'($urandom), acc);
        service(TMO - 1, 1'b1, 8'($urandom_range(1, 255)), 0, low);
    endtask

    task automatic test_back_to_back;
        bit acc; int low;
        push(1'($urandom), 2'($urandom), 16'($urandom), acc);
        tick; tick;
        for (int i = 0; i < 5; i++) begin
            push(1'($urandom), 2'($urandom), 16'($urandom), acc);
            n_total++;
            if (acc !== (i < DEPTH)) $display("FAIL b2b_ready[%0d]: cmd_ready=%b required %b", i, acc, (i < DEPTH));
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            service(int'($urandom_range(0, 10)), 1'b1, 8'($urandom), 0, low);
            if (i > 0) begin
                n_total++;
                if (low < GAPC) $display("FAIL b2b_gap[%0d]: start-low cycles=%0d required >=%0d", i, low, GAPC);
                else n_pass++;
            end
        end
    endtask

    task automatic test_resp_backpressure;
        bit acc; int low;
        push(1'b1, 2'($urandom), 16'($urandom), acc);
        push(1'($urandom), 2'($urandom), 16'($urandom), acc);
        service(5, 1'b1, 8'($urandom), 10, low);
        service(3, 1'b1, 8'($urandom), 0, low);
    endtask

    task automatic test_reset_mid_busy;
        bit acc; bit quiet;
        push(1'($urandom), 2'b11, 16'hFFFF, acc);
        tick; tick; tick;
        push(1'b1, 2'($urandom), 16'($urandom), acc);
        push(1'b0, 2'($urandom), 16'($urandom), acc);
        rst_n = 1'b0;
        tick;
        q.delete();
        exp_tmo_cnt = 0;
        n_total++;
        if ({spi_enable, spi_start_transaction, rsp_valid, spi_slave, spi_operation, spi_outgoing_data, timeout_count} !== '0)
            $display("FAIL midbusy_reset: en=%b st=%b rv=%b sl=%b wd=%h tc=%0d required all 0",
                     spi_enable, spi_start_transaction, rsp_valid, spi_slave, spi_outgoing_data, timeout_count);
        else n_pass++;
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            tick;
            if (spi_start_transaction !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
        end
        n_total++;
        if (!quiet) $display("FAIL midbusy_quiet: activity after reset, required empty FIFO and no response");
        else n_pass++;
    endtask

    task automatic test_eot_ignored;
        bit acc; int low;
        spi_end_of_transaction = 1'b1; spi_incoming_data = 8'($urandom);
        tick;
        spi_end_of_transaction = 1'b0;
        repeat (4) tick;
        n_total++;
        if ({rsp_valid, spi_start_transaction} !== 2'b00)
            $display("FAIL eot_idle: rsp_valid/start=%b required 00", {rsp_valid, spi_start_transaction});
        else n_pass++;
        push(1'b1, 2'($urandom), 16'($urandom), acc);
        service(7, 1'b1, 8'($urandom), 0, low);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write_latency;
        test_read;
        test_random;
        test_timeout;
        test_back_to_back;
        test_resp_backpressure;
        test_reset_mid_busy;
        test_eot_ignored;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_transaction_sequencer.md
SPI_TRANSACTION_SEQUENCER -- requirements
Module: spi_transaction_sequencer

Interface
REQ-001 Parameters SHALL be: CMD_DEPTH, 4, command FIFO depth (power of 2, >=2); TIMEOUT_CYCLES, 1024, max cycles awaiting end of transaction; INTER_GAP, 2, idle cycles between transactions (0 allowed).
REQ-002 Ports SHALL be: clk  in  1  clock; rst_n  in  1  reset (synchronous, active-low).
REQ-003 cmd_valid in 1, cmd_ready out 1, cmd_op in 1 (1=read, 0=write), cmd_slave in 2, cmd_wdata in 16: command push, transferred when cmd_valid and cmd_ready are both high on a rising edge.
REQ-004 rsp_valid out 1, rsp_ready in 1, rsp_rdata out 8, rsp_op out 1, rsp_slave out 2, rsp_timeout out 1: response handshake.
REQ-005 spi_enable out 1, spi_start_transaction out 1, spi_slave out 2, spi_operation out 1, spi_outgoing_data out 16: drive the SPI master.
REQ-006 spi_end_of_transaction in 1 and spi_incoming_data in 8: received from the SPI master.
REQ-007 timeout_count out 8: saturating count of timed-out transactions.

Function
REQ-008 The FSM SHALL have states IDLE, ISSUE, BUSY, RESP and GAP.
REQ-009 cmd_ready SHALL equal !fifo_full as registered. A push while full SHALL be rejected, even if a pop occurs in the same cycle.
REQ-010 The FIFO SHALL have no bypass. A push into an empty FIFO becomes poppable on the next cycle.
REQ-011 IDLE with the FIFO non-empty SHALL pop one entry, latch op/slave/wdata into spi_operation/spi_slave/spi_outgoing_data, and go to ISSUE.
REQ-012 ISSUE SHALL last 1 cycle, assert spi_start_transaction, clear the wait counter and go to BUSY.
REQ-013 spi_start_transaction SHALL stay high through BUSY and go low on the cycle after leaving BUSY.
REQ-014 spi_operation, spi_slave and spi_outgoing_data SHALL stay stable from ISSUE until the next pop.
REQ-015 Latency: with the FIFO empty in IDLE, spi_start_transaction SHALL rise exactly 2 cycles after the accepting edge.
REQ-016 BUSY SHALL increment the wait counter each cycle. A high spi_end_of_transaction SHALL capture rdata (spi_incoming_data if read, 8'h00 if write), set rsp_timeout=0 and go to RESP.
REQ-017 BUSY SHALL time out when the wait counter reaches TIMEOUT_CYCLES-1 without spi_end_of_transaction: rdata=8'h00, rsp_timeout=1, timeout_count +1 saturating at 255, go to RESP.
REQ-018 If end_of_transaction and the timeout terminal count occur in the same cycle, end_of_transaction SHALL win (rsp_timeout=0).
REQ-019 spi_end_of_transaction SHALL be treated as a pulse, acted on only in BUSY and ignored in every other state.
REQ-020 RESP SHALL hold rsp_valid=1 with all rsp_* fields stable until rsp_ready is high on an edge, then go to GAP, or to IDLE if INTER_GAP=0.
REQ-021 GAP SHALL stay for INTER_GAP cycles with spi_start_transaction low, then go to IDLE.
REQ-022 Commands SHALL be serviced strictly in FIFO order, one outstanding transaction at a time.
REQ-023 spi_enable SHALL be 0 during reset and 1 from the first cycle after rst_n is high.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter, minimum 1 bit.

Reset
REQ-025 On rst_n low at an edge: state=IDLE, FIFO emptied (cmd_ready=1 on the next cycle), spi_start_transaction=0, spi_enable=0, spi_slave=0, spi_operation=0, spi_outgoing_data=0, rsp_valid=0, rsp_rdata=0, rsp_op=0, rsp_slave=0, rsp_timeout=0, timeout_count=0, all counters=0.
REQ-026 Reset during BUSY or RESP SHALL abandon the transaction with no response, and reset SHALL take priority over every other event.

Structure
REQ-027 The shared package SHALL hold the state enum, the OP_READ=1 and OP_WRITE=0 constants, and the default parameter values.
REQ-028 The FIFO SHALL be a separate sub-module spi_cmd_fifo (sync, width 19, depth CMD_DEPTH, full/empty flags). The FSM and counters SHALL live in the top module.

Verification
REQ-029 Push write {op=0, slave=2'b01, wdata=16'hCC82}, pulse eot after 40 cycles -> start rises 2 cycles after accept, spi_outgoing_data=16'hCC82, response rdata=8'h00, timeout=0.
REQ-030 Push read slave=2'b10, eot with spi_incoming_data=8'h95 -> rsp_rdata=8'h95, rsp_op=1, rsp_slave=2'b10.
REQ-031 Push 5 commands back-to-back (CMD_DEPTH=4) with the FSM stalled -> 4 accepted, cmd_ready low on the 5th; responses return in order, separated by >=INTER_GAP idle cycles with start low.
REQ-032 No eot with TIMEOUT_CYCLES=16 -> after 16 BUSY cycles rsp_timeout=1 and timeout_count=1. Eot on the terminal cycle -> rsp_timeout=0.
REQ-033 Hold rsp_ready low for 10 cycles, then high -> rsp_* stable throughout, no new start_transaction until the handshake.
REQ-034 Assert rst_n low mid-BUSY with 2 commands queued -> all outputs at reset values, no response, FIFO empty afterwards.
